// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S core: instruction decode, control states, ALU op codes.
// Also holds the branch-condition and ALU-op helpers used by the control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    LOAD_ADDR,
    LOAD_WB,
    STORE,
    MOVE,
    ALU,
    BRANCH,
    HALT
  } ctrl_state_type;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // True when the instruction redirects the PC given the registered flags.
  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic z, input logic n, input logic ov);
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = z;
      I_BNZERO: taken = !z;
      I_BNEG:   taken = n;
      I_BNNEG:  taken = !n;
      I_BOV:    taken = ov;
      I_BNOV:   taken = !ov;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    logic [1:0] op;
    op = ALU_OR;
    case (instr)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the K&S core: FETCH -> DECODE -> execute, driving datapath strobes.
// Outputs decode from the state register (ALU op from the stable IR decode); counts retired instructions.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [15:0]             retired_count
);

  ctrl_state_type state, state_next;
  logic           retire;

  // Carry-out is not a branch condition in this ISA.
  logic unused_carry;
  assign unused_carry = unsigned_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      retired_count <= 16'h0000;
    end else begin
      state <= state_next;
      if (retire) retired_count <= retired_count + 16'h0001;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:     state_next = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:  state_next = LOAD_ADDR;
          I_STORE: state_next = STORE;
          I_MOVE:  state_next = MOVE;
          I_ADD, I_SUB, I_AND, I_OR: state_next = ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
            state_next = branch_taken(decoded_instruction, zero_op, neg_op, signed_overflow)
                         ? BRANCH : FETCH;
          I_HALT:  state_next = HALT;
          default: state_next = FETCH;
        endcase
      end
      LOAD_ADDR: state_next = LOAD_WB;
      LOAD_WB:   state_next = FETCH;
      STORE:     state_next = FETCH;
      MOVE:      state_next = FETCH;
      ALU:       state_next = FETCH;
      BRANCH:    state_next = FETCH;
      HALT:      state_next = HALT;
      default:   state_next = FETCH;
    endcase
  end

  // HALT counts as retiring since it never returns to FETCH.
  assign retire = ((state_next == FETCH) && (state != FETCH)) ||
                  ((state == DECODE) && (state_next == HALT));

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      FETCH: begin
        addr_sel  = 1'b1;
        ir_enable = 1'b1;
      end
      DECODE:  pc_enable = 1'b1;
      LOAD_WB: write_reg_enable = 1'b1;
      STORE:   ram_write_enable = 1'b1;
      MOVE: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      ALU: begin
        operation        = alu_op(decoded_instruction);
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
      end
      BRANCH: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
      end
      HALT:    halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit, plus hand sequences for halt, async reset and counter wrap.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic                    clk;
  logic                    rst_n;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [15:0]             retired_count;

  control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .retired_count       (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0], wr_reg, flags, ram_wr, halt}
  logic [10:0] ow;
  assign ow = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  localparam logic [10:0] W_FETCH  = 11'b001_1_0_00_0_0_0_0;
  localparam logic [10:0] W_DECODE = 11'b010_0_0_00_0_0_0_0;
  localparam logic [10:0] W_LADDR  = 11'b000_0_0_00_0_0_0_0;
  localparam logic [10:0] W_LWB    = 11'b000_0_0_00_1_0_0_0;
  localparam logic [10:0] W_STORE  = 11'b000_0_0_00_0_0_1_0;
  localparam logic [10:0] W_MOVE   = 11'b000_0_1_00_1_0_0_0;
  localparam logic [10:0] W_ADD    = 11'b000_0_1_01_1_1_0_0;
  localparam logic [10:0] W_SUB    = 11'b000_0_1_10_1_1_0_0;
  localparam logic [10:0] W_AND    = 11'b000_0_1_11_1_1_0_0;
  localparam logic [10:0] W_OR     = 11'b000_0_1_00_1_1_0_0;
  localparam logic [10:0] W_BRANCH = 11'b110_0_0_00_0_0_0_0;
  localparam logic [10:0] W_HALT   = 11'b000_0_0_00_0_0_0_1;

  typedef struct {
    string                   name;
    decoded_instruction_type instr;
    logic                    z, n, ov;
    int                      len;
    logic [10:0]             e1, e2;
  } vec_t;

  vec_t        vecs[22];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input decoded_instruction_type ins,
                         input logic z, input logic n, input logic ov, input int len,
                         input logic [10:0] e1, input logic [10:0] e2);
    vecs[i].name = nm; vecs[i].instr = ins;
    vecs[i].z = z; vecs[i].n = n; vecs[i].ov = ov;
    vecs[i].len = len; vecs[i].e1 = e1; vecs[i].e2 = e2;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH.
  task automatic run_vec(input vec_t v);
    chk({v.name, " fetch"}, {5'd0, ow}, {5'd0, W_FETCH});
    decoded_instruction = v.instr;
    zero_op = v.z; neg_op = v.n; signed_overflow = v.ov;
    unsigned_overflow = ~v.ov;
    @(negedge clk);
    chk({v.name, " decode"}, {5'd0, ow}, {5'd0, W_DECODE});
    @(negedge clk);
    chk({v.name, " exec1"}, {5'd0, ow}, {5'd0, v.e1});
    if (v.len == 4) begin
      @(negedge clk);
      chk({v.name, " exec2"}, {5'd0, ow}, {5'd0, v.e2});
    end
    if (v.len >= 3) @(negedge clk);
    exp_count = exp_count + 16'h0001;
    chk({v.name, " retired"}, retired_count, exp_count);
  endtask

  initial begin
    set_vec(0,  "nop",       I_NOP,    0, 0, 0, 2, W_FETCH,  W_FETCH);
    set_vec(1,  "nop2",      I_NOP,    1, 1, 1, 2, W_FETCH,  W_FETCH);
    set_vec(2,  "add",       I_ADD,    0, 0, 0, 3, W_ADD,    W_FETCH);
    set_vec(3,  "sub",       I_SUB,    0, 0, 0, 3, W_SUB,    W_FETCH);
    set_vec(4,  "and",       I_AND,    0, 0, 0, 3, W_AND,    W_FETCH);
    set_vec(5,  "or",        I_OR,     1, 1, 1, 3, W_OR,     W_FETCH);
    set_vec(6,  "move",      I_MOVE,   0, 0, 0, 3, W_MOVE,   W_FETCH);
    set_vec(7,  "load",      I_LOAD,   0, 0, 0, 4, W_LADDR,  W_LWB);
    set_vec(8,  "store",     I_STORE,  0, 0, 0, 3, W_STORE,  W_FETCH);
    set_vec(9,  "branch",    I_BRANCH, 0, 0, 0, 3, W_BRANCH, W_FETCH);
    set_vec(10, "bzero_t",   I_BZERO,  1, 0, 0, 3, W_BRANCH, W_FETCH);
    set_vec(11, "bzero_n",   I_BZERO,  0, 1, 1, 2, W_FETCH,  W_FETCH);
    set_vec(12, "bnzero_t",  I_BNZERO, 0, 0, 0, 3, W_BRANCH, W_FETCH);
    set_vec(13, "bnzero_n",  I_BNZERO, 1, 0, 0, 2, W_FETCH,  W_FETCH);
    set_vec(14, "bneg_t",    I_BNEG,   0, 1, 0, 3, W_BRANCH, W_FETCH);
    set_vec(15, "bneg_n",    I_BNEG,   1, 0, 1, 2, W_FETCH,  W_FETCH);
    set_vec(16, "bnneg_t",   I_BNNEG,  1, 0, 1, 3, W_BRANCH, W_FETCH);
    set_vec(17, "bnneg_n",   I_BNNEG,  0, 1, 0, 2, W_FETCH,  W_FETCH);
    set_vec(18, "bov_t",     I_BOV,    0, 0, 1, 3, W_BRANCH, W_FETCH);
    set_vec(19, "bov_n",     I_BOV,    1, 1, 0, 2, W_FETCH,  W_FETCH);
    set_vec(20, "bnov_t",    I_BNOV,   1, 1, 0, 3, W_BRANCH, W_FETCH);
    set_vec(21, "bnov_n",    I_BNOV,   0, 0, 1, 2, W_FETCH,  W_FETCH);

    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    zero_op = 1'b0; neg_op = 1'b0; unsigned_overflow = 1'b0; signed_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {5'd0, ow}, {5'd0, W_FETCH});
    chk("reset count", retired_count, 16'h0000);
    rst_n = 1'b1;
    exp_count = 16'h0000;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Counter wrap: preload all-ones, retire one NOP.
    force dut.retired_count = 16'hFFFF;
    #1 release dut.retired_count;
    exp_count = 16'hFFFF;
    run_vec(vecs[0]);

    // Reset during LOAD_WB must drop the register write without waiting for a clock.
    decoded_instruction = I_LOAD;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("lwb before reset", {5'd0, ow}, {5'd0, W_LWB});
    rst_n = 1'b0;
    #1;
    chk("lwb async reset", {5'd0, ow}, {5'd0, W_FETCH});
    chk("lwb reset count", retired_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'h0000;
    run_vec(vecs[2]);

    // HALT: two cycles, then stuck with the counter frozen.
    chk("halt fetch", {5'd0, ow}, {5'd0, W_FETCH});
    decoded_instruction = I_HALT;
    @(negedge clk);
    chk("halt decode", {5'd0, ow}, {5'd0, W_DECODE});
    exp_count = exp_count + 16'h0001;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("halt hold", {5'd0, ow}, {5'd0, W_HALT});
      chk("halt count", retired_count, exp_count);
    end
    rst_n = 1'b0;
    #1;
    chk("halt reset outputs", {5'd0, ow}, {5'd0, W_FETCH});
    chk("halt reset count", retired_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    decoded_instruction = I_NOP;
    @(negedge clk);
    chk("post reset decode", {5'd0, ow}, {5'd0, W_DECODE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
